// File: rtl/llc_output_encoder_pkg.sv
// llc_output_encoder_pkg: shared LLC egress message types, constants and FSM states
package llc_output_encoder_pkg;
  localparam int LINE_ADDR_BITS = 26;
  localparam int CACHE_ID_WIDTH = 4;
  localparam int BITS_PER_LINE = 64;
  localparam logic [2:0] RSP_DATA = 3'd1;
  localparam logic [2:0] FWD_INV = 3'd2;
  localparam logic [2:0] FWD_GETS = 3'd3;
  typedef enum logic {IDLE, BURST} inval_state_t;
  typedef struct packed {
    logic [2:0] coh_msg;
    logic [CACHE_ID_WIDTH-1:0] req_id;
    logic [CACHE_ID_WIDTH-1:0] dest_id;
    logic [LINE_ADDR_BITS-1:0] addr;
    logic [BITS_PER_LINE-1:0] line;
  } llc_rsp_out_t;
  typedef struct packed {
    logic [2:0] coh_msg;
    logic [CACHE_ID_WIDTH-1:0] req_id;
    logic [CACHE_ID_WIDTH-1:0] dest_id;
    logic [LINE_ADDR_BITS-1:0] addr;
  } llc_fwd_out_t;
  typedef struct packed {
    logic hwrite;
    logic [2:0] hsize;
    logic [1:0] hprot;
    logic [LINE_ADDR_BITS-1:0] addr;
    logic [BITS_PER_LINE-1:0] line;
  } llc_mem_req_t;
  typedef struct packed {
    logic [2:0] coh_msg;
    logic [CACHE_ID_WIDTH-1:0] req_id;
    logic [LINE_ADDR_BITS-1:0] addr;
    logic [BITS_PER_LINE-1:0] line;
  } llc_dma_rsp_out_t;
endpackage

// File: rtl/llc_output_encoder_fifo.sv
// llc_fifo: DEPTH-entry FIFO with valid/ready drain; accepts a push into a full FIFO when it pops that cycle
//   clk, rst (async active-low)
//   push_i/din_i    : enqueue (ignored when can_push_o is low)
//   ready_i         : consumer ready; pop = valid_o & ready_i
//   valid_o/dout_o  : head entry
//   can_push_o      : not full, or full and popping this cycle
module llc_fifo #(
  parameter int DEPTH = 2,
  parameter type dtype = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  dtype din_i,
  input  logic ready_i,
  output logic valid_o,
  output dtype dout_o,
  output logic can_push_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  dtype mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic pop, push;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign valid_o = cnt_q != '0;
  assign dout_o = mem_q[rd_q];
  assign pop = valid_o & ready_i;
  assign can_push_o = (cnt_q != CW'(DEPTH)) | pop;
  assign push = push_i & can_push_o;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= din_i;
      if (push) wr_q <= nxt(wr_q);
      if (pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/llc_output_encoder.sv
// llc_output_encoder: buffers LLC egress messages per channel and expands invalidations into per-sharer bursts
//   clk, rst (async active-low)
//   send_* / *_in          : pipeline enqueue requests, accepted atomically unless out_stall
//   send_inval, inval_*    : start a burst of FWD_INV messages, one per set sharer bit
//   out_stall              : this cycle's sends are rejected on every channel
//   inval_busy             : burst in progress (burst owns the fwd channel)
//   llc_*_valid/ready/data : egress valid/ready interfaces
module llc_output_encoder
  import llc_output_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NUM_PORTS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic send_rsp_out,
  input  logic [$bits(llc_rsp_out_t)-1:0] rsp_out_in,
  input  logic send_fwd_out,
  input  logic [$bits(llc_fwd_out_t)-1:0] fwd_out_in,
  input  logic send_mem_req,
  input  logic [$bits(llc_mem_req_t)-1:0] mem_req_in,
  input  logic send_dma_rsp,
  input  logic [$bits(llc_dma_rsp_out_t)-1:0] dma_rsp_in,
  input  logic send_inval,
  input  logic [NUM_PORTS-1:0] inval_sharers,
  input  logic [LINE_ADDR_BITS-1:0] inval_addr,
  input  logic [CACHE_ID_WIDTH-1:0] inval_req_id,
  output logic out_stall,
  output logic inval_busy,
  output logic llc_rsp_out_valid,
  input  logic llc_rsp_out_ready,
  output logic [$bits(llc_rsp_out_t)-1:0] llc_rsp_out,
  output logic llc_fwd_out_valid,
  input  logic llc_fwd_out_ready,
  output logic [$bits(llc_fwd_out_t)-1:0] llc_fwd_out,
  output logic llc_mem_req_valid,
  input  logic llc_mem_req_ready,
  output logic [$bits(llc_mem_req_t)-1:0] llc_mem_req,
  output logic llc_dma_rsp_out_valid,
  input  logic llc_dma_rsp_out_ready,
  output logic [$bits(llc_dma_rsp_out_t)-1:0] llc_dma_rsp_out
);
  inval_state_t state_q, state_d;
  logic [NUM_PORTS-1:0] shr_q, shr_d;
  logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CACHE_ID_WIDTH-1:0] rid_q, rid_d, idx;
  logic rsp_can, fwd_can, mem_can, dma_can, accept, fwd_push;
  llc_fwd_out_t fwd_din, burst_msg;
  function automatic logic [CACHE_ID_WIDTH-1:0] lowest(input logic [NUM_PORTS-1:0] v);
    lowest = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) if (v[i]) lowest = CACHE_ID_WIDTH'(i);
  endfunction
  assign inval_busy = state_q == BURST;
  assign idx = lowest(shr_q);
  assign burst_msg = '{coh_msg: FWD_INV, req_id: rid_q, dest_id: idx, addr: addr_q};
  // fwd and inval are stalled for the whole burst so the burst never competes for the fwd FIFO
  assign out_stall = (send_rsp_out & ~rsp_can) | (send_fwd_out & ~fwd_can) |
                     (send_mem_req & ~mem_can) | (send_dma_rsp & ~dma_can) |
                     ((send_fwd_out | send_inval) & inval_busy);
  assign accept = ~out_stall;
  assign fwd_push = inval_busy ? fwd_can : send_fwd_out & accept;
  assign fwd_din = inval_busy ? burst_msg : llc_fwd_out_t'(fwd_out_in);
  always_comb begin
    state_d = state_q;
    shr_d = shr_q;
    addr_d = addr_q;
    rid_d = rid_q;
    if (!inval_busy && send_inval && accept) begin
      shr_d = inval_sharers;
      addr_d = inval_addr;
      rid_d = inval_req_id;
      state_d = |inval_sharers ? BURST : IDLE;
    end else if (inval_busy && fwd_can) begin
      shr_d = shr_q & ~(NUM_PORTS'(1) << idx);
      state_d = |shr_d ? BURST : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shr_q <= '0;
      addr_q <= '0;
      rid_q <= '0;
    end else begin
      state_q <= state_d;
      shr_q <= shr_d;
      addr_q <= addr_d;
      rid_q <= rid_d;
    end
  end
  llc_fifo #(.DEPTH(DEPTH), .dtype(llc_rsp_out_t)) u_rsp (
    .clk, .rst, .push_i(send_rsp_out & accept), .din_i(rsp_out_in), .ready_i(llc_rsp_out_ready),
    .valid_o(llc_rsp_out_valid), .dout_o(llc_rsp_out), .can_push_o(rsp_can));
  llc_fifo #(.DEPTH(DEPTH), .dtype(llc_fwd_out_t)) u_fwd (
    .clk, .rst, .push_i(fwd_push), .din_i(fwd_din), .ready_i(llc_fwd_out_ready),
    .valid_o(llc_fwd_out_valid), .dout_o(llc_fwd_out), .can_push_o(fwd_can));
  llc_fifo #(.DEPTH(DEPTH), .dtype(llc_mem_req_t)) u_mem (
    .clk, .rst, .push_i(send_mem_req & accept), .din_i(mem_req_in), .ready_i(llc_mem_req_ready),
    .valid_o(llc_mem_req_valid), .dout_o(llc_mem_req), .can_push_o(mem_can));
  llc_fifo #(.DEPTH(DEPTH), .dtype(llc_dma_rsp_out_t)) u_dma (
    .clk, .rst, .push_i(send_dma_rsp & accept), .din_i(dma_rsp_in), .ready_i(llc_dma_rsp_out_ready),
    .valid_o(llc_dma_rsp_out_valid), .dout_o(llc_dma_rsp_out), .can_push_o(dma_can));
endmodule

// File: doc/llc_output_encoder.md
Name: llc_output_encoder

Overview:
- Egress counterpart to the LLC input decoder: accepts outgoing messages from the LLC process stage and buffers them per channel.
- Drives them onto the four LLC output interfaces (rsp_out, fwd_out, mem_req, dma_rsp_out) using valid/ready handshakes.
- Expands one invalidation request into a serial burst of fwd_out messages, one per sharer.
- Back-pressures the pipeline via out_stall so that a multi-channel send is accepted atomically.

Parameters:
- DEPTH, 2, entries per channel FIFO (power of two, at least 1).
- NUM_PORTS, 16, width of the sharers bitmap (number of L2 caches).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- send_rsp_out  in  1  request to enqueue rsp_out_in
- rsp_out_in  in  $bits(llc_rsp_out_t)  response packet
- send_fwd_out  in  1  request to enqueue fwd_out_in
- fwd_out_in  in  $bits(llc_fwd_out_t)  forward packet
- send_mem_req  in  1  request to enqueue mem_req_in
- mem_req_in  in  $bits(llc_mem_req_t)  memory request packet
- send_dma_rsp  in  1  request to enqueue dma_rsp_in
- dma_rsp_in  in  $bits(llc_dma_rsp_out_t)  DMA response packet
- send_inval  in  1  start an invalidation burst
- inval_sharers  in  NUM_PORTS  sharer bitmap for the burst
- inval_addr  in  LINE_ADDR_BITS  line address for the burst
- inval_req_id  in  CACHE_ID_WIDTH  requestor id carried in each inval
- out_stall  out  1  current-cycle sends are not accepted
- inval_busy  out  1  burst in progress
- llc_rsp_out_valid  out  1 / llc_rsp_out_ready  in  1 / llc_rsp_out  out  $bits(llc_rsp_out_t)
- llc_fwd_out_valid  out  1 / llc_fwd_out_ready  in  1 / llc_fwd_out  out  $bits(llc_fwd_out_t)
- llc_mem_req_valid  out  1 / llc_mem_req_ready  in  1 / llc_mem_req  out  $bits(llc_mem_req_t)
- llc_dma_rsp_out_valid  out  1 / llc_dma_rsp_out_ready  in  1 / llc_dma_rsp_out  out  $bits(llc_dma_rsp_out_t)

Behaviour:
- Reset (rst=0, async):
  - All FIFOs empty; all *_valid=0; payload outputs 0.
  - FSM in IDLE; inval_busy=0; sharer shadow register 0.
  - out_stall=0 while reset is asserted.
- Channel FIFOs (one per channel, DEPTH entries):
  - *_valid = !empty; the payload output is the head entry.
  - Pop when valid && ready.
  - A push into a full FIFO is accepted in the same cycle as a pop from it (full-with-pop counts as not full).
- Atomic acceptance:
  - out_stall = (any send_x asserted whose FIFO is full and not popping) | (send_fwd_out & inval_busy) | (send_inval & inval_busy).
  - When out_stall=1, no push occurs on any channel.
  - When out_stall=0, every asserted send_x pushes in that cycle.
  - Latency from push to *_valid is one cycle.
- Invalidation FSM:
  - IDLE:
    - On send_inval & !out_stall, latch inval_sharers, inval_addr and inval_req_id.
    - If the latched bitmap is all-zero, stay in IDLE and emit nothing.
    - Otherwise go to BURST.
  - BURST, each cycle:
    - idx = lowest set bit of the shadow register.
    - If the fwd FIFO can accept, push {coh_msg=FWD_INV, addr, req_id, dest_id=idx} and clear bit idx.
    - Otherwise hold.
    - When the bitmap becomes zero after a push, return to IDLE.
  - inval_busy = (state==BURST).
  - In BURST the burst owns the fwd FIFO; a concurrent send_fwd_out raises out_stall.
  - The other channels still accept sends, subject to the atomic rule.
- Simultaneous events:
  - send_inval together with send_rsp_out in IDLE: both are accepted in the same cycle.
  - The first inval is pushed the next cycle.
- Order:
  - Within a channel, FIFO order is preserved.
  - No ordering is guaranteed across channels.
- Reset mid-burst: the burst is aborted and FIFOs are cleared; no partial state survives.

Decomposition:
- Shared package (cache_types/cache_consts): llc_rsp_out_t, llc_fwd_out_t, llc_mem_req_t, llc_dma_rsp_out_t; FWD_INV; LINE_ADDR_BITS; CACHE_ID_WIDTH.
- Sub-module: reuse llc_fifo, instanced four times with dtype set per channel.
- Priority encoder: a local function, not a module.

Test Plan:
- Reset, then send_rsp_out=1 once with all readies=1: llc_rsp_out_valid=1 the next cycle with identical payload, then 0; out_stall never asserted.
- mem_req_ready=0 and 3 send_mem_req with DEPTH=2: 2 accepted; third cycle out_stall=1. Then ready=1: the third send is accepted the same cycle as the pop, and the output order is 1,2,3.
- send_inval with inval_sharers=16'b0000_0000_0010_0101 and fwd_ready=1: fwd_out dest_id 0, 2, 5 on consecutive cycles; inval_busy high for 3 cycles.
- The same burst with fwd_ready toggling 1,0,1,0: dest_id order unchanged, no drops or duplicates; send_fwd_out during the burst yields out_stall=1.
- send_inval with sharers=0: no fwd_out, inval_busy stays 0, out_stall=0.
- Reset asserted after the first inval of a 4-sharer burst: all valids 0 asynchronously; after release no further fwd_out is issued.
